// File: rtl/rvv_xrf_wb_arbiter_if.sv
// Bundle of retire-slot request lanes and the single scalar-regfile write port
// of the writeback arbiter. The master drives requests and write-port ready.
interface rvv_xrf_wb_arbiter_if #(
  parameter int NUM_SLOT = 4,
  parameter int DEPTH    = 4,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 32
);
  // Handshake: a slot moves on slot_valid_i[i] && slot_ready_o[i], the write
  // port moves on wb_valid_o && wb_ready_i; valid never waits on ready.
  logic [NUM_SLOT-1:0]             slot_valid_i;
  logic [NUM_SLOT-1:0][IDX_W-1:0]  slot_idx_i;
  logic [NUM_SLOT-1:0][DATA_W-1:0] slot_data_i;
  logic [NUM_SLOT-1:0]             slot_ready_o;
  logic                            wb_valid_o;
  logic [IDX_W-1:0]                wb_addr_o;
  logic [DATA_W-1:0]               wb_data_o;
  logic                            wb_ready_i;
  logic [$clog2(DEPTH):0]          count_o;
  logic                            idle_o;

  modport master (
    output slot_valid_i, slot_idx_i, slot_data_i, wb_ready_i,
    input  slot_ready_o, wb_valid_o, wb_addr_o, wb_data_o, count_o, idle_o
  );

  modport slave (
    input  slot_valid_i, slot_idx_i, slot_data_i, wb_ready_i,
    output slot_ready_o, wb_valid_o, wb_addr_o, wb_data_o, count_o, idle_o
  );
endinterface

// File: rtl/rvv_xrf_wb_arbiter.sv
// Merges NUM_SLOT retire-slot writebacks into one regfile write port through a
// DEPTH-entry FIFO. Optional same-cycle bypass when empty: RVV_XRF_WB_BYPASS_EN.
module rvv_xrf_wb_arbiter #(
  parameter int NUM_SLOT = 4,
  parameter int DEPTH    = 4,
  parameter int IDX_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  rvv_xrf_wb_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t                         mem [DEPTH];
  logic [PTR_W-1:0]               head;
  logic [PTR_W-1:0]               tail;
  logic [CNT_W-1:0]               count;
  logic [CNT_W-1:0]               free;
  logic [CNT_W-1:0]               n_push;
  logic [CNT_W-1:0]               acc;
  logic                           pop;
  logic [NUM_SLOT-1:0]            push_valid;
  logic [NUM_SLOT-1:0]            push_en;
  logic [NUM_SLOT-1:0][PTR_W-1:0] waddr;

  // Space freed by a pop this cycle is only visible next cycle.
  assign free = CNT_W'(DEPTH) - count;
  assign pop  = (count != '0) && bus.wb_ready_i;

`ifdef RVV_XRF_WB_BYPASS_EN
  logic [NUM_SLOT-1:0] byp_sel;
  logic                byp_active;
  logic                byp_fire;
  logic [IDX_W-1:0]    byp_idx;
  logic [DATA_W-1:0]   byp_data;

  always_comb begin
    byp_sel  = bus.slot_valid_i & (~bus.slot_valid_i + NUM_SLOT'(1));
    byp_idx  = '0;
    byp_data = '0;
    for (int i = 0; i < NUM_SLOT; i++) begin
      if (byp_sel[i]) begin
        byp_idx  = bus.slot_idx_i[i];
        byp_data = bus.slot_data_i[i];
      end
    end
  end

  assign byp_active     = (count == '0) && (|bus.slot_valid_i);
  assign byp_fire       = byp_active && bus.wb_ready_i;
  // A bypassed slot retires straight to the port and takes no FIFO space.
  assign push_valid     = bus.slot_valid_i & ~(byp_fire ? byp_sel : '0);
  assign bus.slot_ready_o = push_en | (byp_fire ? byp_sel : '0);
  assign bus.wb_valid_o = (count != '0) || byp_active;
  assign bus.wb_addr_o  = (count != '0) ? mem[head].idx  : byp_idx;
  assign bus.wb_data_o  = (count != '0) ? mem[head].data : byp_data;
`else
  assign push_valid       = bus.slot_valid_i;
  assign bus.slot_ready_o = push_en;
  assign bus.wb_valid_o   = (count != '0);
  assign bus.wb_addr_o    = mem[head].idx;
  assign bus.wb_data_o    = mem[head].data;
`endif

  // Prefix rule: slot i goes in only if all older valid slots also fit, so
  // each accepted slot's running valid count is also its offset from tail.
  always_comb begin
    acc     = '0;
    n_push  = '0;
    push_en = '0;
    waddr   = '0;
    for (int i = 0; i < NUM_SLOT; i++) begin
      if (push_valid[i]) acc = acc + CNT_W'(1);
      push_en[i] = push_valid[i] && (acc <= free);
      waddr[i]   = tail + acc[PTR_W-1:0] - PTR_W'(1);
      if (push_en[i]) n_push = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop);
      tail  <= tail + n_push[PTR_W-1:0];
      count <= count + n_push - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOT; i++) begin
      if (push_en[i]) mem[waddr[i]] <= {bus.slot_idx_i[i], bus.slot_data_i[i]};
    end
  end

  assign bus.count_o = count;
  assign bus.idle_o  = (count == '0) && !(|bus.slot_valid_i);
endmodule

// File: doc/rvv_xrf_wb_arbiter.md
RVV_XRF_WB_ARBITER -- requirements
Module: rvv_xrf_wb_arbiter

Interface
- REQ-001: The block SHALL take parameter NUM_SLOT, default 4, meaning the number of retire slots requesting scalar-regfile writeback.
- REQ-002: The block SHALL take parameter DEPTH, default 4, meaning the entries in the internal writeback FIFO; it must be a power of 2 and at least NUM_SLOT.
- REQ-003: The block SHALL take parameter IDX_W, default 5, meaning the scalar register index width.
- REQ-004: The block SHALL take parameter DATA_W, default 32, meaning the scalar data width.
- REQ-005: Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
- REQ-006: Port rst, input, 1 bit: synchronous, active-high reset.
- REQ-007: Port slot_valid_i, input, [NUM_SLOT]: per-slot writeback request; slot 0 is the oldest in ROB order.
- REQ-008: Port slot_idx_i, input, [NUM_SLOT][IDX_W]: per-slot destination register index.
- REQ-009: Port slot_data_i, input, [NUM_SLOT][DATA_W]: per-slot writeback data.
- REQ-010: Port slot_ready_o, output, [NUM_SLOT]: per-slot accept.
- REQ-011: Ports wb_valid_o (output, 1), wb_addr_o (output, IDX_W), wb_data_o (output, DATA_W) and wb_ready_i (input, 1): the single regfile write port.
- REQ-012: Port count_o, output, $clog2(DEPTH)+1 bits: registered FIFO occupancy.
- REQ-013: Port idle_o, output, 1 bit: high when count_o==0 and no slot_valid_i bit is set.

Function
- REQ-014: A slot SHALL transfer on slot_valid_i[i]&&slot_ready_o[i]; the write port SHALL transfer on wb_valid_o&&wb_ready_i.
- REQ-015: free SHALL be computed as DEPTH-count from registered count only; a pop in a cycle SHALL NOT create space for pushes in that cycle.
- REQ-016: slot_ready_o[i] SHALL be 1 iff the number of valid slots with index 0..i is at most free (prefix rule), so acceptance is always a contiguous-oldest subset of the valid slots.
- REQ-017: Accepted slots SHALL be written at tail in ascending slot index, skipping invalid slots; tail SHALL advance by n_push modulo DEPTH.
- REQ-018: Without bypass, wb_valid_o SHALL equal (count!=0), and wb_addr_o/wb_data_o SHALL come from the head entry, with a minimum latency of 1 cycle from slot accept to wb_valid_o.
- REQ-019: On a pop, head SHALL advance by 1 modulo DEPTH.
- REQ-020: The next count SHALL equal count+n_push-pop, with simultaneous push and pop both applied.
- REQ-021: While wb_valid_o&&!wb_ready_i, wb_addr_o and wb_data_o SHALL hold stable.
- REQ-022: When full (count==DEPTH), all slot_ready_o SHALL be 0; when empty, wb_valid_o SHALL be 0 (unless bypass per REQ-026).
- REQ-023: Writeback order SHALL be strict acceptance order, and slot order within a cycle; no entry SHALL be dropped or duplicated.

Reset
- REQ-024: While rst is high at a clk edge, head, tail and count SHALL clear to 0. Next cycle, wb_valid_o=0, slot_ready_o reflects free=DEPTH and count_o=0; FIFO data SHALL be don't-care.
- REQ-025: A reset asserted mid-operation SHALL discard all buffered entries, including one currently presented with wb_valid_o high, and no pop SHALL be counted.

Configuration
- REQ-026: With macro RVV_XRF_WB_BYPASS_EN defined and count==0, wb_valid_o SHALL be high if any slot is valid, and wb_addr_o/wb_data_o SHALL come combinationally from the lowest-index valid slot. If wb_ready_i is also high, that slot SHALL complete directly without entering the FIFO and SHALL not consume free space. If wb_ready_i is low, it SHALL be pushed normally. Without the macro, behaviour SHALL be exactly REQ-018, with no combinational path from slot_* to wb_*.

Verification
- REQ-027: After reset, slots 0..3 are valid in one cycle with idx 1,2,3,4 and wb_ready_i=1. All four SHALL be accepted, and wb_addr_o SHALL show 1,2,3,4 on the next four cycles (no bypass).
- REQ-028: With wb_ready_i=0, push 4 entries, then present slots 0,1 valid. slot_ready_o SHALL be 0000, and count_o SHALL hold at 4.
- REQ-029: With count=3 and slots 0,2,3 valid, slot_ready_o SHALL be 0001; only slot 0 is accepted, and count becomes 4.
- REQ-030: Only slot 2 valid, idx 7, data 0xDEADBEEF. It SHALL be accepted and written with addr 7, data 0xDEADBEEF; with bypass, this occurs in the same cycle when empty and wb_ready_i=1.
- REQ-031: Run 20 random pushes/pops across multiple head/tail wrap-arounds. The output sequence SHALL equal the accept sequence, and count_o SHALL never exceed 4.
- REQ-032: Assert rst while count=3 and wb_valid_o=1. Next cycle, count_o=0, wb_valid_o=0 (no slots valid), and idle_o=1.
